// File: rtl/odd_wb_pipe_pkg.sv
// Shared unit identifiers, default latencies and the stage-register record
// for the odd-pipe result staging pipeline.
package odd_wb_pipe_pkg;

    typedef enum logic [1:0] {
        UNIT_BR   = 2'd0,
        UNIT_PERM = 2'd1,
        UNIT_LS   = 2'd2
    } odd_unit_e;

    localparam int LAT_BR   = 1;
    localparam int LAT_PERM = 3;
    localparam int LAT_LS   = 6;

    localparam int DEF_DEPTH     = 7;
    localparam int DEF_NUM_UNITS = 3;
    localparam logic [DEF_NUM_UNITS*4-1:0] DEF_UNIT_LAT =
        {4'(LAT_LS), 4'(LAT_PERM), 4'(LAT_BR)};

    // Field widths of the stage record; the top checks its own parameters against these.
    localparam int ODD_ADDR_WD = 7;
    localparam int ODD_DATA_WD = 128;
    localparam int ODD_UW      = 2;

    typedef struct packed {
        logic                   vld;
        logic                   wr;
        logic [ODD_UW-1:0]      unit;
        logic [ODD_ADDR_WD-1:0] addr;
        logic                   rdy;
        logic [ODD_DATA_WD-1:0] data;
    } odd_stage_t;

    function automatic logic [3:0] lat_of(input logic [63:0] lat_vec, input int idx);
        return lat_vec[idx*4 +: 4];
    endfunction

endpackage

// File: rtl/odd_wb_pipe_if.sv
// Issue/result/flush inputs and forward/writeback outputs of the odd-pipe
// staging pipeline, bundled for the pipeline and whoever drives it.
interface odd_wb_pipe_if
    import odd_wb_pipe_pkg::*;
#(
    parameter int DEPTH     = DEF_DEPTH,
    parameter int NUM_UNITS = DEF_NUM_UNITS,
    parameter int ADDR_WD   = ODD_ADDR_WD,
    parameter int DATA_WD   = ODD_DATA_WD,
    parameter int UW        = $clog2(NUM_UNITS)
);
    localparam int FW = $clog2(DEPTH + 1);

    logic                         iss_vld;
    logic [UW-1:0]                iss_unit;
    logic [ADDR_WD-1:0]           iss_addr;
    logic                         iss_wr;
    logic [NUM_UNITS-1:0]         res_vld;
    logic [NUM_UNITS*DATA_WD-1:0] res_data;
    logic                         flush_vld;
    logic [FW-1:0]                flush_stage;

    logic [DEPTH-1:0]             fwd_vld;
    logic [DEPTH*ADDR_WD-1:0]     fwd_addr;
    logic [DEPTH*DATA_WD-1:0]     fwd_data;
    logic                         wb_en;
    logic [ADDR_WD-1:0]           wb_addr;
    logic [DATA_WD-1:0]           wb_data;
    logic                         err;

    modport master (
        output iss_vld, iss_unit, iss_addr, iss_wr,
        output res_vld, res_data, flush_vld, flush_stage,
        input  fwd_vld, fwd_addr, fwd_data, wb_en, wb_addr, wb_data, err
    );

    modport slave (
        input  iss_vld, iss_unit, iss_addr, iss_wr,
        input  res_vld, res_data, flush_vld, flush_stage,
        output fwd_vld, fwd_addr, fwd_data, wb_en, wb_addr, wb_data, err
    );

endinterface

// File: rtl/odd_wb_pipe_stage.sv
// One pipeline stage: registers the entry advancing from the previous stage,
// merging a unit result whose latency lands here and applying branch flush.
module odd_wb_stage
    import odd_wb_pipe_pkg::*;
#(
    parameter int                     STAGE     = 1,
    parameter int                     NUM_UNITS = DEF_NUM_UNITS,
    parameter logic [NUM_UNITS*4-1:0] UNIT_LAT  = DEF_UNIT_LAT,
    parameter int                     FW        = 3
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  odd_stage_t                       prev,
    input  logic [NUM_UNITS-1:0]             res_vld,
    input  logic [NUM_UNITS*ODD_DATA_WD-1:0] res_data,
    input  logic                             flush_vld,
    input  logic [FW-1:0]                    flush_f,
    output odd_stage_t                       cur,
    output logic                             drop_err
);

    odd_stage_t             nxt;
    logic                   hit;
    logic                   kill;
    logic [ODD_DATA_WD-1:0] hit_data;

    // A unit with latency L targets the entry sitting in stage L, which lands here as STAGE = L+1.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        drop_err = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (lat_of(64'(UNIT_LAT), i) == 4'(STAGE - 1) && res_vld[i]) begin
                if (prev.vld && prev.unit == ODD_UW'(i) && !prev.rdy) begin
                    hit      = 1'b1;
                    hit_data = res_data[i*ODD_DATA_WD +: ODD_DATA_WD];
                end else begin
                    drop_err = 1'b1;
                end
            end
        end

        kill = flush_vld && (FW'(STAGE - 1) < flush_f);

        nxt = prev;
        if (hit && !kill) begin
            nxt.rdy  = 1'b1;
            nxt.data = hit_data;
        end
        if (kill) begin
            nxt.vld = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

endmodule

// File: rtl/odd_wb_pipe.sv
// Odd-pipe result staging pipeline: DEPTH chained stages with per-stage
// forwarding taps, register-file writeback from the last stage and sticky err.
module odd_wb_pipe
    import odd_wb_pipe_pkg::*;
#(
    parameter int                     DEPTH     = DEF_DEPTH,
    parameter int                     NUM_UNITS = DEF_NUM_UNITS,
    parameter logic [NUM_UNITS*4-1:0] UNIT_LAT  = DEF_UNIT_LAT,
    parameter int                     ADDR_WD   = ODD_ADDR_WD,
    parameter int                     DATA_WD   = ODD_DATA_WD,
    parameter int                     UW        = $clog2(NUM_UNITS)
) (
    input  logic         clk,
    input  logic         rst_n,
    odd_wb_pipe_if.slave bus
);

    localparam int FW = $clog2(DEPTH + 1);

    if (ADDR_WD != ODD_ADDR_WD || DATA_WD != ODD_DATA_WD || UW != ODD_UW ||
        DEPTH < 2 || DEPTH > 16) begin : g_param_check
        $error("odd_wb_pipe: widths must match odd_stage_t and DEPTH must be 2..16");
    end

    odd_stage_t    iss_entry;
    odd_stage_t    stages [1:DEPTH];
    logic [DEPTH:1] drop_err;
    logic [FW-1:0] flush_f;
    odd_stage_t    last;
    logic          wb_miss;
    logic          err_q;

    always_comb begin
        iss_entry      = '0;
        iss_entry.vld  = bus.iss_vld;
        iss_entry.wr   = bus.iss_wr;
        iss_entry.unit = ODD_UW'(bus.iss_unit);
        iss_entry.addr = ODD_ADDR_WD'(bus.iss_addr);
    end

    // Flush stages beyond DEPTH behave as DEPTH; compare one bit wider to keep the clamp honest.
    always_comb begin
        flush_f = bus.flush_stage;
        if ({1'b0, bus.flush_stage} > (FW + 1)'(DEPTH)) begin
            flush_f = FW'(DEPTH);
        end
    end

    for (genvar s = 1; s <= DEPTH; s++) begin : g_stage
        odd_stage_t prev;

        if (s == 1) begin : g_first
            assign prev = iss_entry;
        end else begin : g_chain
            assign prev = stages[s-1];
        end

        odd_wb_stage #(
            .STAGE     (s),
            .NUM_UNITS (NUM_UNITS),
            .UNIT_LAT  (UNIT_LAT),
            .FW        (FW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .prev      (prev),
            .res_vld   (bus.res_vld),
            .res_data  (bus.res_data),
            .flush_vld (bus.flush_vld),
            .flush_f   (flush_f),
            .cur       (stages[s]),
            .drop_err  (drop_err[s])
        );

        assign bus.fwd_vld[s-1]                       = stages[s].vld & stages[s].wr & stages[s].rdy;
        assign bus.fwd_addr[(s-1)*ADDR_WD +: ADDR_WD] = ADDR_WD'(stages[s].addr);
        assign bus.fwd_data[(s-1)*DATA_WD +: DATA_WD] = DATA_WD'(stages[s].data);
    end

    assign last        = stages[DEPTH];
    assign wb_miss     = last.vld & last.wr & ~last.rdy;
    assign bus.wb_en   = last.vld & last.wr & last.rdy;
    assign bus.wb_addr = ADDR_WD'(last.addr);
    assign bus.wb_data = DATA_WD'(last.data);

    // A writeback that never received its result flags err in that same cycle and stays latched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((|drop_err) || wb_miss) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q | wb_miss;

endmodule

// File: doc/odd_wb_pipe.md
# odd_wb_pipe

Parametrised odd-pipe result staging pipeline for the SPU-Lite core. It accepts issued odd-pipe instructions and tracks each one for DEPTH stages. Results from NUM_UNITS execution units (permute, local-store, branch/channel) are merged into each entry at that unit's fixed latency. The block exposes per-stage forwarding taps to the hazard/forward network and drives register-file writeback from the last stage. It also supports a branch flush of younger entries.

## Interface
- DEPTH, 7: number of stages, numbered 1..DEPTH; writeback is taken from stage DEPTH.
- NUM_UNITS, 3: number of result-producing units.
- UNIT_LAT, {4'd6,4'd3,4'd1}: packed NUM_UNITS×4 bits; entry i is unit i's latency, each value in 1..DEPTH-1.
- ADDR_WD, 7: register address width.
- DATA_WD, 128: result width.
- UW, $clog2(NUM_UNITS): unit index width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- iss_vld  in  1  issue strobe.
- iss_unit  in  UW  unit the instruction executes on.
- iss_addr  in  ADDR_WD  destination RT address.
- iss_wr  in  1  instruction writes RT.
- res_vld  in  NUM_UNITS  per-unit result strobe.
- res_data  in  NUM_UNITS×DATA_WD  per-unit result data.
- flush_vld  in  1  branch flush request.
- flush_stage  in  $clog2(DEPTH+1)  stage of the flushing branch.
- fwd_vld  out  DEPTH  per stage: entry valid, writes RT, and data ready.
- fwd_addr  out  DEPTH×ADDR_WD  per-stage destination address.
- fwd_data  out  DEPTH×DATA_WD  per-stage data.
- wb_en  out  1  register-file write enable.
- wb_addr  out  ADDR_WD  writeback address.
- wb_data  out  DATA_WD  writeback data.
- err  out  1  sticky protocol error.

## Operation
- Each stage register holds: vld, wr, unit, addr, rdy, data.
- Every cycle, stage s+1 is loaded from stage s. Stage 1 is loaded from the iss_* inputs. There is no stall.
- Result merge:
  - res_vld[i] is legal only in a cycle where stage L=UNIT_LAT[i] holds vld=1, unit=i, rdy=0.
  - When legal, stage L+1 is loaded with rdy=1 and data=res_data[i].
  - When illegal, the result is dropped and err is set.
- Flush: when flush_vld=1 with F=flush_stage, the entries currently in stages 1..F-1 and a same-cycle issue are invalidated as they advance. Stage F and older are kept.
  - F=0 flushes nothing.
  - F≥DEPTH+1 is clamped to DEPTH.
- Flush vs. result: if the same cycle's result targets a flushed entry, the flush wins. The result is dropped silently, with no err.
- Writeback, driven from stage DEPTH:
  - wb_en = vld&wr&rdy; wb_addr and wb_data come from that stage.
  - An entry with vld&wr&!rdy at stage DEPTH sets err and suppresses wb_en.
  - When wb_en=0, wb_addr and wb_data hold the stage contents, which are don't-care.
- Forwarding taps: fwd_vld[s] = vld&wr&rdy of stage s. fwd_addr and fwd_data are raw stage contents.
- Instructions with wr=0 (branches, stores) still occupy stages and accept results, but never forward or write back.
- err clears only on reset.
- Reset: all stage vld, rdy, and data are cleared to 0. All outputs read 0.
- Reset is asynchronous mid-operation: every in-flight entry is discarded immediately.

## Timing
- An issue sampled at edge t occupies stage 1 during cycle t+1 and stage s during cycle t+s.
- A unit-i result is presented during cycle t+L_i. It is visible on the stage L_i+1 tap during cycle t+L_i+1.
- Writeback is asserted during cycle t+DEPTH, so issue-to-writeback latency is DEPTH cycles.
- All outputs are registered-state decodes, with no combinational path from inputs. Result-to-forward latency is 1 cycle.
- Back-to-back issue is allowed every cycle. Throughput is 1 instruction per cycle.
- The design is synthesisable with DEPTH between 2 and 16.

## Structure
- defines_pkg gets:
  - the odd-pipe unit index constants UNIT_BR=0, UNIT_PERM=1, UNIT_LS=2;
  - the default latency localparams;
  - a packed struct typedef odd_stage_t {vld, wr, unit, addr, rdy, data}, parametrised via localparams.
- Sub-module odd_wb_stage: one stage register plus its result-merge and flush logic. The top module generates DEPTH instances and the writeback/err logic.

## Test plan
- Reset and single issue: hold rst_n low, then release. Issue unit 1 (perm, L=3), addr 7'd5, wr=1; drive res_vld[1] with 128'hA5 at cycle +3 → fwd_vld[4..7] set at cycles +4..+7; wb_en=1, wb_addr=5, wb_data=128'hA5 at cycle +7; err=0.
- Back-to-back mix: issue LS (addr 10), perm (addr 11), and branch (wr=0) on consecutive cycles, each with its correct result → wb at cycles +7 and +8 with correct data; the branch slot has wb_en=0 and fwd_vld never set.
- Flush: fill stages 1..6. Assert flush_vld with flush_stage=4 while a perm result targets stage 3 → entries from stages 1..3 and the concurrent issue never write back; stages 4..6 write back; err=0.
- Protocol errors:
  - res_vld[2] with no LS entry in stage 6 → err=1 and data dropped.
  - A separate run with the perm result missing → err=1 at writeback and wb_en=0.
- Async reset mid-flight: pulse rst_n low between edges with 5 entries in flight → all outputs are 0 immediately; no writeback occurs after release.
- Parameter sweep: DEPTH=4 with UNIT_LAT={3,2,1} → DEPTH-cycle latency and taps are correct.
